// File: rtl/prog_mem.sv
`default_nettype none
// ============================================================================
// Module  : prog_mem
// Brief   : Loadable instruction memory with zero-latency fetch port and
//           core run gating (cpu_run) driven by a three-state load FSM.
// Revision: 1.0
// ============================================================================
module prog_mem #(
  parameter int AW    = 1,
  parameter int DW    = 1,
  parameter int DEPTH = 2**AW
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data,
  input  logic          ld_start,
  input  logic          ld_go,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          ld_done,
  output logic [DW-1:0] ld_csum,
  output logic          cpu_run
);

  localparam int c_PTR_W = $clog2(DEPTH + 1);
  localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(DEPTH - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_LOAD = 2'd1;
  localparam logic [1:0] c_RUN  = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [c_PTR_W-1:0] r_ptr;
  logic [DW-1:0]      r_csum;
  logic               r_done;
  logic               r_cpu_run;
  logic [DW-1:0]      r_mem [DEPTH];

  logic w_in_load;
  logic w_accept;
  logic w_last;

  assign w_in_load = (r_state == c_LOAD);
  // A restart pulse takes priority over a word presented in the same cycle.
  assign w_accept  = w_in_load & ld_valid & ~ld_start;
  assign w_last    = w_accept & (r_ptr == c_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (ld_start)   w_state_nxt = c_LOAD;
        else if (ld_go) w_state_nxt = c_RUN;
      end
      c_LOAD: begin
        if (ld_start)    w_state_nxt = c_LOAD;
        else if (w_last) w_state_nxt = c_RUN;
      end
      c_RUN: begin
        if (ld_start) w_state_nxt = c_LOAD;
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= c_IDLE;
      r_ptr     <= '0;
      r_csum    <= '0;
      r_done    <= 1'b0;
      r_cpu_run <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= w_last;
      r_cpu_run <= (w_state_nxt == c_RUN);
      if (ld_start) begin
        r_ptr  <= '0;
        r_csum <= '0;
      end else if (w_accept) begin
        r_ptr  <= r_ptr + 1'b1;
        r_csum <= r_csum ^ ld_data;
      end
    end
  end

  // Per-word storage so the whole array clears on asynchronous reset.
  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    logic w_we;
    assign w_we = w_accept & (r_ptr[AW-1:0] == AW'(i));

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        r_mem[i] <= '0;
      end else if (w_we) begin
        r_mem[i] <= ld_data;
      end
    end
  end

  assign data     = (r_state == c_RUN) ? r_mem[addr] : '0;
  assign ld_ready = w_in_load;
  assign ld_done  = r_done;
  assign ld_csum  = r_csum;
  assign cpu_run  = r_cpu_run;

endmodule
`default_nettype wire

// File: tb/tb_prog_mem.sv
`default_nettype none
// ============================================================================
// Module  : tb_prog_mem
// Brief   : Directed self-checking bench for prog_mem (AW=1, DW=1).
// Revision: 1.0
// ============================================================================
module tb_prog_mem;

  logic       clk;
  logic       n_rst;
  logic [0:0] addr;
  logic [0:0] data;
  logic       ld_start;
  logic       ld_go;
  logic       ld_valid;
  logic [0:0] ld_data;
  logic       ld_ready;
  logic       ld_done;
  logic [0:0] ld_csum;
  logic       cpu_run;

  int checks   = 0;
  int failures = 0;

  prog_mem #(.AW(1), .DW(1)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .addr     (addr),
    .data     (data),
    .ld_start (ld_start),
    .ld_go    (ld_go),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_done  (ld_done),
    .ld_csum  (ld_csum),
    .cpu_run  (cpu_run)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input string tag, input logic [0:0] a, input logic [0:0] exp);
    addr = a;
    #1;
    chk(tag, 32'(data), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_rst = 1'b0; addr = '0; ld_start = 1'b0; ld_go = 1'b0;
    ld_valid = 1'b0; ld_data = '0;

    // 1: reset state, then idle fetches
    #3;
    chk("rst_cpu_run", 32'(cpu_run), 0);
    chk("rst_ready",   32'(ld_ready), 0);
    chk("rst_done",    32'(ld_done), 0);
    chk("rst_csum",    32'(ld_csum), 0);
    tick(); tick();
    n_rst = 1'b1;
    ld_valid = 1'b1; ld_data = 1'b1;   // ignored outside LOAD
    for (int i = 0; i < 4; i++) begin
      tick();
      ld_valid = 1'b0;
      rd("idle_data", 1'(i), 1'b0);
      chk("idle_cpu_run", 32'(cpu_run), 0);
      chk("idle_ready",   32'(ld_ready), 0);
      chk("idle_csum",    32'(ld_csum), 0);
    end

    // 2: back-to-back load of {1,0}
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    chk("s2_ready", 32'(ld_ready), 1);
    rd("s2_load_data_forced", 1'b0, 1'b0);
    ld_valid = 1'b1; ld_data = 1'b1; tick();
    chk("s2_done_early", 32'(ld_done), 0);
    ld_data = 1'b0; tick();
    ld_valid = 1'b0;
    chk("s2_done",    32'(ld_done), 1);
    chk("s2_cpu_run", 32'(cpu_run), 1);
    chk("s2_csum",    32'(ld_csum), 1);
    chk("s2_ready0",  32'(ld_ready), 0);
    rd("s2_mem0", 1'b0, 1'b1);
    rd("s2_mem1", 1'b1, 1'b0);
    tick();
    chk("s2_done_pulse", 32'(ld_done), 0);

    // 3: same load with gapped valid
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    chk("s3_csum_clr", 32'(ld_csum), 0);
    ld_valid = 1'b1; ld_data = 1'b1; tick();
    ld_valid = 1'b0;
    chk("s3_gap_ready1", 32'(ld_ready), 1);
    tick();
    chk("s3_gap_ready2", 32'(ld_ready), 1);
    chk("s3_gap_done",   32'(ld_done), 0);
    tick();
    ld_valid = 1'b1; ld_data = 1'b0; tick();
    ld_valid = 1'b0;
    chk("s3_done",    32'(ld_done), 1);
    chk("s3_cpu_run", 32'(cpu_run), 1);
    chk("s3_csum",    32'(ld_csum), 1);
    rd("s3_mem0", 1'b0, 1'b1);
    rd("s3_mem1", 1'b1, 1'b0);

    // 4: reload from RUN with {0,1}
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    chk("s4_run_fall", 32'(cpu_run), 0);
    ld_valid = 1'b1; ld_data = 1'b0; tick();
    chk("s4_run_mid", 32'(cpu_run), 0);
    ld_data = 1'b1; tick();
    ld_valid = 1'b0;
    chk("s4_done",    32'(ld_done), 1);
    chk("s4_cpu_run", 32'(cpu_run), 1);
    chk("s4_csum",    32'(ld_csum), 1);
    rd("s4_mem0", 1'b0, 1'b0);
    rd("s4_mem1", 1'b1, 1'b1);
    // ld_go and ld_valid are ignored in RUN
    ld_go = 1'b1; ld_valid = 1'b1; ld_data = 1'b1; tick();
    ld_go = 1'b0; ld_valid = 1'b0;
    chk("s4_go_ignored",  32'(cpu_run), 1);
    chk("s4_csum_hold",   32'(ld_csum), 1);
    rd("s4_mem0_hold", 1'b0, 1'b0);

    // 5: restart mid-load, same-cycle word dropped
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 1'b1; tick();
    chk("s5_csum_first", 32'(ld_csum), 1);
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    chk("s5_csum_restart", 32'(ld_csum), 0);
    chk("s5_done_restart", 32'(ld_done), 0);
    ld_data = 1'b0; tick();
    chk("s5_done_early", 32'(ld_done), 0);
    chk("s5_run_early",  32'(cpu_run), 0);
    tick();
    ld_valid = 1'b0;
    chk("s5_done",    32'(ld_done), 1);
    chk("s5_cpu_run", 32'(cpu_run), 1);
    chk("s5_csum",    32'(ld_csum), 0);
    rd("s5_mem0", 1'b0, 1'b0);
    rd("s5_mem1", 1'b1, 1'b0);

    // 6: async reset mid-load, then release with ld_go
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 1'b1; tick();
    ld_valid = 1'b0;
    chk("s6_csum_pre", 32'(ld_csum), 1);
    n_rst = 1'b0;
    #1;
    chk("s6_rst_ready",   32'(ld_ready), 0);
    chk("s6_rst_csum",    32'(ld_csum), 0);
    chk("s6_rst_cpu_run", 32'(cpu_run), 0);
    #1;
    n_rst = 1'b1;
    tick();
    ld_go = 1'b1; tick(); ld_go = 1'b0;
    chk("s6_cpu_run", 32'(cpu_run), 1);
    rd("s6_mem0", 1'b0, 1'b0);
    rd("s6_mem1", 1'b1, 1'b0);

    // IDLE with ld_start and ld_go together: start wins
    n_rst = 1'b0; #1; n_rst = 1'b1;
    tick();
    ld_start = 1'b1; ld_go = 1'b1; tick(); ld_start = 1'b0; ld_go = 1'b0;
    chk("prio_ready",   32'(ld_ready), 1);
    chk("prio_cpu_run", 32'(cpu_run), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
